// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the programmable delay line.
// Holds the fill-tracking state encoding and default geometry.
package delay_line_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 240;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        PRIMED = 2'd2
    } state_t;

    function automatic int sat_inc(input int v, input int max_v);
        return (v >= max_v) ? max_v : v + 1;
    endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// DEPTH:1 selector for one {valid, data} word of the delay chain.
// Kept standalone so a pipeline stage can be inserted here later.
module delay_tap_mux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 240,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH:0] words,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH:0]            word
);

    always_comb begin
        word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (SEL_W'(k) == sel) word = words[k];
        end
    end

endmodule

// File: rtl/delay_line_prog.sv
// Enable-gated WIDTH-bit delay chain with a runtime-selected output tap
// and a fill tracker reporting when the selected tap holds real data.
module delay_line_prog
    import delay_line_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic             flush,
    input  logic             dly_ld,
    input  logic [SEL_W-1:0] dly,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             primed,
    output logic [1:0]       state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [SEL_W-1:0] MAX_TAP = SEL_W'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH:0]   taps;
    logic [WIDTH:0]              tap_word;
    logic [SEL_W-1:0]            dly_q;
    logic [SEL_W-1:0]            dly_nxt;
    logic [CW-1:0]               fill_cnt;
    logic [CW-1:0]               fill_nxt;
    logic                        primed_nxt;
    logic                        shift;
    state_t                      state_q;
    state_t                      state_nxt;

    // A flush drops the coincident sample, so data only moves without one.
    assign shift = en & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else if (shift) begin
            stage <= {stage[DEPTH-2:0], din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[DEPTH-2:0], din_vld};
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            taps[k] = {vld[k], stage[k]};
        end
    end

    delay_tap_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .words (taps),
        .sel   (dly_q),
        .word  (tap_word)
    );

    always_comb begin
        dly_nxt = dly_q;
        if (dly_ld) begin
            dly_nxt = (32'(dly) > 32'(DEPTH - 1)) ? MAX_TAP : dly;
        end
        fill_nxt = fill_cnt;
        if (flush) begin
            fill_nxt = '0;
        end else if (en) begin
            fill_nxt = CW'(sat_inc(int'(fill_cnt), DEPTH));
        end
        primed_nxt = 32'(fill_nxt) > 32'(dly_nxt);
        if (fill_nxt == '0) begin
            state_nxt = EMPTY;
        end else if (primed_nxt) begin
            state_nxt = PRIMED;
        end else begin
            state_nxt = FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q    <= '0;
            fill_cnt <= '0;
            state_q  <= EMPTY;
            primed   <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            dly_q    <= dly_nxt;
            fill_cnt <= fill_nxt;
            state_q  <= state_nxt;
            primed   <= primed_nxt;
            dout     <= tap_word[WIDTH-1:0];
            dout_vld <= tap_word[WIDTH];
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_delay_line_prog.sv
// Randomised bench for delay_line_prog against a sample-history model.
module tb_delay_line_prog;

    localparam int D = 240;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = '0;
    logic       din_vld = 1'b0;
    logic       flush = 1'b0;
    logic       dly_ld = 1'b0;
    logic [7:0] dly = '0;
    logic [7:0] dout;
    logic       dout_vld;
    logic       primed;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    // model: hist[n] is the n-th most recent accepted sample {vld, data}
    logic [8:0] hist[$];
    int         m_fill;
    int         m_dly;
    logic [7:0] e_dout;
    logic       e_vld;
    logic       e_primed;
    logic [1:0] e_state;

    delay_line_prog dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .din_vld  (din_vld),
        .flush    (flush),
        .dly_ld   (dly_ld),
        .dly      (dly),
        .dout     (dout),
        .dout_vld (dout_vld),
        .primed   (primed),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back(9'h0);
        m_fill = 0;
        m_dly = 0;
        e_dout = '0;
        e_vld = 1'b0;
        e_primed = 1'b0;
        e_state = 2'd0;
    endtask

    task automatic model_edge(input logic e, input logic [7:0] d,
                              input logic v, input logic f,
                              input logic l, input int dl);
        logic [8:0] t;
        t = hist[m_dly];
        e_dout = t[7:0];
        e_vld = t[8];
        if (f) begin
            for (int i = 0; i < hist.size(); i++) begin
                t = hist[i];
                t[8] = 1'b0;
                hist[i] = t;
            end
            m_fill = 0;
        end else if (e) begin
            hist.push_front({v, d});
            void'(hist.pop_back());
            m_fill = (m_fill < D) ? m_fill + 1 : D;
        end
        if (l) m_dly = (dl > D - 1) ? D - 1 : dl;
        e_primed = m_fill > m_dly;
        e_state = (m_fill == 0) ? 2'd0 : (e_primed ? 2'd2 : 2'd1);
    endtask

    task automatic step(input logic e, input logic [7:0] d, input logic v,
                        input logic f, input logic l, input int dl);
        en = e;
        din = d;
        din_vld = v;
        flush = f;
        dly_ld = l;
        dly = 8'(dl);
        @(posedge clk);
        model_edge(e, d, v, f, l, dl);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_dout got %h want 00", dout);
        end
        total++;
        if (dout_vld !== 1'b0 || primed !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got %b%b want 00", dout_vld, primed);
        end
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got %0d want 0", state);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b0, 0);
            total++;
            if ({dout_vld, dout, primed, state} !==
                {e_vld, e_dout, e_primed, e_state}) begin
                bad++;
                $display("FAIL ramp[%0d] got %h want %h", i,
                         {dout_vld, dout, primed, state},
                         {e_vld, e_dout, e_primed, e_state});
            end
            if (i == 0) begin
                total++;
                if (state !== 2'd2 || primed !== 1'b1) begin
                    bad++;
                    $display("FAIL ramp_prime got st=%0d p=%b want st=2 p=1",
                             state, primed);
                end
            end
            if (i == 1) begin
                total++;
                if (dout !== 8'h01 || dout_vld !== 1'b1) begin
                    bad++;
                    $display("FAIL ramp_first got %h/%b want 01/1",
                             dout, dout_vld);
                end
            end
        end
    endtask

    task automatic test_long();
        apply_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 239);
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL long_load got st=%0d want 0", state);
        end
        for (int i = 0; i <= 240; i++) begin
            step(1'b1, (i == 0) ? 8'hA5 : 8'h00, i == 0, 1'b0, 1'b0, 0);
            total++;
            if ({dout_vld, dout, primed, state} !==
                {e_vld, e_dout, e_primed, e_state}) begin
                bad++;
                $display("FAIL long[%0d] got %h want %h", i,
                         {dout_vld, dout, primed, state},
                         {e_vld, e_dout, e_primed, e_state});
            end
            total++;
            if (state !== ((i < 239) ? 2'd1 : 2'd2)) begin
                bad++;
                $display("FAIL long_state[%0d] got %0d", i, state);
            end
        end
        total++;
        if (dout !== 8'hA5 || dout_vld !== 1'b1) begin
            bad++;
            $display("FAIL long_marker got %h/%b want a5/1", dout, dout_vld);
        end
    endtask

    task automatic test_gaps();
        int         found;
        logic [7:0] prev;
        logic       e;
        apply_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5);
        found = -1;
        prev = '0;
        for (int i = 0; i < 30; i++) begin
            e = (i % 2 == 0);
            step(e, (i == 0) ? 8'hA5 : 8'($urandom_range(0, 8'hA4)),
                 (i == 0) ? 1'b1 : 1'($urandom), 1'b0, 1'b0, 0);
            total++;
            if ({dout_vld, dout, primed, state} !==
                {e_vld, e_dout, e_primed, e_state}) begin
                bad++;
                $display("FAIL gaps[%0d] got %h want %h", i,
                         {dout_vld, dout, primed, state},
                         {e_vld, e_dout, e_primed, e_state});
            end
            if (!e) prev = dout;
            if (e && i > 0) begin
                total++;
                if (dout !== prev) begin
                    bad++;
                    $display("FAIL gaps_hold[%0d] got %h want %h",
                             i, dout, prev);
                end
            end
            if (dout == 8'hA5 && found < 0) found = i;
        end
        total++;
        if (found != 11) begin
            bad++;
            $display("FAIL gaps_latency got step %0d want 11", found);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 0);
        end
        total++;
        if (state !== 2'd2) begin
            bad++;
            $display("FAIL flush_pre got st=%0d want 2", state);
        end
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 0);
        total++;
        if (state !== 2'd0 || primed !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear got st=%0d p=%b want 0/0",
                     state, primed);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 0);
            total++;
            if ({dout_vld, dout, primed, state} !==
                {e_vld, e_dout, e_primed, e_state}) begin
                bad++;
                $display("FAIL refill[%0d] got %h want %h", k,
                         {dout_vld, dout, primed, state},
                         {e_vld, e_dout, e_primed, e_state});
            end
            if (k == 1) begin
                total++;
                if (dout_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_vld got %b want 0", dout_vld);
                end
            end
            if (k == 3 || k == 4) begin
                total++;
                if (primed !== (k == 4)) begin
                    bad++;
                    $display("FAIL refill_prime[%0d] got %b", k, primed);
                end
            end
        end
    endtask

    task automatic test_retap();
        apply_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 0);
        end
        total++;
        if (state !== 2'd2) begin
            bad++;
            $display("FAIL retap_pre got st=%0d want 2", state);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 20);
        total++;
        if (state !== 2'd1 || primed !== 1'b0) begin
            bad++;
            $display("FAIL retap_fill got st=%0d p=%b want 1/0",
                     state, primed);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 255);
        for (int i = 0; i < 230; i++) begin
            step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 0);
            total++;
            if ({dout_vld, dout, primed, state} !==
                {e_vld, e_dout, e_primed, e_state}) begin
                bad++;
                $display("FAIL retap[%0d] got %h want %h", i,
                         {dout_vld, dout, primed, state},
                         {e_vld, e_dout, e_primed, e_state});
            end
        end
        total++;
        if (state !== 2'd2 || primed !== 1'b1) begin
            bad++;
            $display("FAIL retap_clamp got st=%0d p=%b want 2/1",
                     state, primed);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'($urandom_range(1, 255)), 1'b1, 1'b0, 1'b0, 0);
        end
        total++;
        if (dout_vld !== 1'b1 || state !== 2'd2) begin
            bad++;
            $display("FAIL arst_pre got v=%b st=%0d want 1/2",
                     dout_vld, state);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({dout, dout_vld, primed, state} !== 12'h000) begin
            bad++;
            $display("FAIL arst_now got %h want 000",
                     {dout, dout_vld, primed, state});
        end
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b0, 0);
            total++;
            if ({dout_vld, dout, primed, state} !==
                {e_vld, e_dout, e_primed, e_state}) begin
                bad++;
                $display("FAIL arst_refill[%0d] got %h want %h", i,
                         {dout_vld, dout, primed, state},
                         {e_vld, e_dout, e_primed, e_state});
            end
            if (i < 2) begin
                total++;
                if (dout_vld !== (i == 1) || dout !== ((i == 1) ? 8'h01 : 8'h00)) begin
                    bad++;
                    $display("FAIL arst_first[%0d] got %h/%b", i,
                             dout, dout_vld);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_long();
        test_gaps();
        test_flush();
        test_retap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_line_prog.md
# delay_line_prog

Parametrised, runtime-programmable delay line: the next generation of the fixed single-bit 240-stage shift chain. It delays a WIDTH-bit data word plus a valid flag through up to DEPTH enable-gated stages, with the output tap selected at runtime. A small fill-tracking FSM reports when the selected tap holds genuine data. It sits between the dedicated-input capture logic and the output drivers of the top-level user module.

## Interface
- WIDTH, 8: data bits per stage.
- DEPTH, 240: number of physical stages, minimum 2.
- SEL_W, $clog2(DEPTH): width of the tap-select field.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; all stages shift only when en=1.
- din  in  WIDTH  input word, sampled when en=1.
- din_vld  in  1  valid flag travelling with din.
- flush  in  1  synchronous clear of valid flags and fill count.
- dly_ld  in  1  load pulse for dly.
- dly  in  SEL_W  tap index; delay = dly+1 advances.
- dout  out  WIDTH  registered output word.
- dout_vld  out  1  registered valid flag from the tap.
- primed  out  1  registered; 1 when fill count > dly_q.
- state  out  2  FSM state: 0 EMPTY, 1 FILL, 2 PRIMED.

## Operation
- Storage: stage[0..DEPTH-1] of WIDTH bits plus vld[0..DEPTH-1].
- When en=1: stage[0]<=din, vld[0]<=din_vld, stage[k]<=stage[k-1], vld[k]<=vld[k-1]. When en=0, all stages hold.
- dly_q register, reset value 0. On dly_ld it loads min(dly, DEPTH-1); out-of-range values clamp.
- dout<=stage[dly_q] and dout_vld<=vld[dly_q] every cycle, independent of en.
- fill_cnt counts en=1 cycles since reset or flush. It saturates at DEPTH and is width $clog2(DEPTH+1).
- primed<=(fill_cnt > dly_q), using the updated values of both registers.
- FSM states:
  - EMPTY: fill_cnt=0. en moves it to FILL.
  - FILL: 0<fill_cnt≤dly_q. It moves to PRIMED when fill_cnt becomes > dly_q.
  - PRIMED: fill_cnt>dly_q. A dly_ld to a larger index can return it to FILL.
- flush, in any state: vld[*]<=0, fill_cnt<=0, state<=EMPTY. Data bits are not cleared. flush wins over a simultaneous en, and that sample is dropped.
- dly_ld with en in the same cycle: the shift happens, and the new tap is used from the next edge onward.
- Reset values, applied asynchronously on rst: every stage and vld bit 0, dout=0, dout_vld=0, primed=0, state=EMPTY, dly_q=0, fill_cnt=0. Reset mid-operation discards all in-flight data.

## Timing
- Latency with en held high: a word sampled at edge E appears on dout after edge E+dly_q+1, i.e. dly_q+2 cycles after presentation.
- With en gaps, latency = dly_q+1 enabled edges + 1 output-register edge.
- Minimum latency is 2 cycles (dly_q=0). Maximum is DEPTH+1 cycles.
- Tap change: dout reflects the new tap one edge after the dly_ld edge.
- flush: dout_vld is 0 from the second edge after the flush edge onward. The first edge still registers the pre-flush tap.
- No combinational path from any input to any output.

## Structure
- Package delay_line_pkg holds:
  - the state enum (EMPTY/FILL/PRIMED, 2 bits);
  - the sat_inc helper;
  - the default WIDTH/DEPTH localparams.
- One sub-module, delay_tap_mux: a parametrised DEPTH:1 WIDTH+1-bit mux feeding the output register. It is kept separate so the mux can be pipelined later without touching the shift chain.

## Test plan
- Reset, dly=0, en=1, din ramp 0x01,0x02,… with din_vld=1 → dout=0x01 two cycles after the first sample. primed=1 and state=PRIMED after the first enabled edge.
- dly_ld with dly=239 (DEPTH=240), en=1 continuous, single 0xA5 marker → 0xA5 appears 241 cycles later. state=FILL for cycles 1–239, PRIMED after fill_cnt reaches 240.
- dly=5, en toggled 1,0,1,0… → marker latency equals 6 enabled edges + 1 cycle. Held values stay stable during en=0.
- Run primed at dly=3, then pulse flush together with en → sample dropped, state=EMPTY, dout_vld=0 within 2 cycles, refill needs 4 enabled edges to re-prime.
- In PRIMED with fill_cnt=10, dly_ld to 20 → state=FILL and primed=0 next cycle. dly_ld with dly=255 → dly_q clamps to 239.
- Assert rst asynchronously mid-stream between edges → all outputs 0 immediately. After release, the first valid dout appears only after refill.
